// File: rtl/ysyx_23060203_core_ctrl.sv
// rtl/ysyx_23060203_core_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/WB sequencer for the single-issue core
// Optional perf counters: define YSYX_23060203_PERF_EN to build cycle_cnt/instret_cnt.
module ysyx_23060203_core_ctrl #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_wen,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        ex_valid,
  input  logic        ex_done,
  input  logic        ex_rf_wen,
  output logic        rf_wen,
  input  logic        halt,
  output logic        halted,
  output logic        err,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERR
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      inst_q, inst_d;
  logic             wen_q, wen_d;
  logic             halt_q, halt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      inst_q  <= '0;
      wen_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      inst_q  <= inst_d;
      wen_q   <= wen_d;
      halt_q  <= halt_d;
    end
  end

  // An ack arriving in the same cycle the timeout expires still wins.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    inst_d  = inst_q;
    wen_d   = wen_q;
    halt_d  = halt_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          tmo_d   = '0;
          state_d = S_DECODE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_LIM) state_d = S_ERR;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (ex_done) begin
          wen_d   = ex_rf_wen;
          halt_d  = halt;
          state_d = S_WB;
        end
      end
      S_WB:     state_d = halt_q ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == S_FETCH);
    imem_addr = imem_req ? pc : 32'd0;
    inst      = inst_q;
    ex_valid  = (state_q == S_EXEC);
    rf_wen    = (state_q == S_WB) && wen_q;
    pc_wen    = (state_q == S_WB) && !halt_q;
    halted    = (state_q == S_HALT);
    err       = (state_q == S_ERR);
  end

`ifdef YSYX_23060203_PERF_EN
  logic [63:0] cycle_q, instret_q;
  logic        cnt_active;

  assign cnt_active = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXEC)  || (state_q == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (cnt_active)        cycle_q   <= cycle_q + 64'd1;
      if (state_q == S_WB)   instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = 64'd0;
  assign instret_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_23060203_core_ctrl.sv
// tb/tb_ysyx_23060203_core_ctrl.sv - self-checking bench for ysyx_23060203_core_ctrl
// Expected traces are built per instruction from the sequencing rules; YSYX_23060203_PERF_EN selects counter expectations.
module tb_ysyx_23060203_core_ctrl;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_wen, imem_req, ex_valid, rf_wen, halted, err;
  logic [31:0] imem_addr, inst;
  logic        imem_ack = 1'b0, ex_done = 1'b0, ex_rf_wen = 1'b0, halt = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [63:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  ysyx_23060203_core_ctrl #(.TMO_W(8), .TMO_MAX(TMO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_wen(pc_wen),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .ex_valid(ex_valid),
    .ex_done(ex_done), .ex_rf_wen(ex_rf_wen), .rf_wen(rf_wen),
    .halt(halt), .halted(halted), .err(err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  typedef enum {K_IDLE, K_FETCH, K_DEC, K_EXEC, K_WB, K_HALT, K_ERR} kind_e;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        done, xwen, hlt;
    logic [31:0] pcv;
    logic        req;
    logic [31:0] addr;
    logic        exv, rfw, pcw, hltd, er;
    logic [31:0] ins;
    logic [63:0] cyc, ret;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_inst;
  logic [63:0] m_cyc, m_ret;
  logic        m_wen, m_hlt;
  bit          m_dead;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input kind_e k, input logic ack, input logic [31:0] rd,
                      input logic done, input logic xwen, input logic hlt,
                      input logic [31:0] pcv);
    vec_t v;
    v.ack = ack; v.rdata = rd; v.done = done; v.xwen = xwen; v.hlt = hlt; v.pcv = pcv;
    v.req  = (k == K_FETCH);
    v.addr = v.req ? pcv : 32'd0;
    v.exv  = (k == K_EXEC);
    v.rfw  = (k == K_WB) && m_wen;
    v.pcw  = (k == K_WB) && !m_hlt;
    v.hltd = (k == K_HALT);
    v.er   = (k == K_ERR);
    v.ins  = m_inst;
`ifdef YSYX_23060203_PERF_EN
    v.cyc = m_cyc;
    v.ret = m_ret;
`else
    v.cyc = 64'd0;
    v.ret = 64'd0;
`endif
    if (k == K_FETCH || k == K_DEC || k == K_EXEC || k == K_WB) m_cyc++;
    if (k == K_WB) m_ret++;
    tbl.push_back(v);
  endtask

  // One instruction: ack after da wait cycles, done after dd wait cycles.
  task automatic add_inst(input int da, input logic [31:0] rd, input logic [31:0] pcv,
                          input int dd, input logic wen, input logic hlt);
    if (m_dead) return;
    for (int k = 0; k <= da && k <= TMO; k++)
      push(K_FETCH, k == da, (k == da) ? rd : $urandom, rb(), rb(), rb(), pcv);
    if (da > TMO) begin
      for (int i = 0; i < 3; i++) push(K_ERR, 1'b1, $urandom, rb(), rb(), rb(), pcv);
      m_dead = 1;
      return;
    end
    m_inst = rd;
    push(K_DEC, rb(), $urandom, rb(), rb(), rb(), pcv);
    for (int j = 0; j <= dd; j++)
      push(K_EXEC, rb(), $urandom, j == dd, (j == dd) ? wen : rb(), (j == dd) ? hlt : rb(), pcv);
    m_wen = wen;
    m_hlt = hlt;
    push(K_WB, rb(), $urandom, rb(), rb(), rb(), pcv);
    if (hlt) begin
      for (int i = 0; i < 3; i++) push(K_HALT, 1'b1, $urandom, 1'b1, 1'b1, 1'b0, pcv);
      m_dead = 1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".req"}, imem_req, 1'b0);
    chk({tag, ".addr"}, imem_addr, 32'd0);
    chk({tag, ".inst"}, inst, 32'd0);
    chk({tag, ".exv"}, ex_valid, 1'b0);
    chk({tag, ".rfw"}, rf_wen, 1'b0);
    chk({tag, ".pcw"}, pc_wen, 1'b0);
    chk({tag, ".halted"}, halted, 1'b0);
    chk({tag, ".err"}, err, 1'b0);
    chk({tag, ".cyc"}, cycle_cnt, 64'd0);
    chk({tag, ".ret"}, instret_cnt, 64'd0);
  endtask

  // Called with rst still high at posedge+1; releases it and opens the IDLE cycle.
  task automatic release_and_init();
    rst = 1'b0;
    tbl.delete();
    m_inst = '0; m_cyc = '0; m_ret = '0; m_wen = 1'b0; m_hlt = 1'b0; m_dead = 0;
    push(K_IDLE, rb(), $urandom, rb(), rb(), rb(), $urandom);
  endtask

  task automatic start_run(input string tag);
    rst = 1'b1;
    imem_ack = 1'b1; ex_done = 1'b1; ex_rf_wen = 1'b1; halt = 1'b0; pc = $urandom;
    @(posedge clk); #1;
    check_zero({tag, ".rst"});
    @(posedge clk); #1;
    release_and_init();
  endtask

  task automatic run_q(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      imem_ack = v.ack; imem_rdata = v.rdata; ex_done = v.done;
      ex_rf_wen = v.xwen; halt = v.hlt; pc = v.pcv;
      @(negedge clk);
      chk($sformatf("%s.c%0d.req", tag, i), imem_req, v.req);
      chk($sformatf("%s.c%0d.addr", tag, i), imem_addr, v.addr);
      chk($sformatf("%s.c%0d.inst", tag, i), inst, v.ins);
      chk($sformatf("%s.c%0d.exv", tag, i), ex_valid, v.exv);
      chk($sformatf("%s.c%0d.rfw", tag, i), rf_wen, v.rfw);
      chk($sformatf("%s.c%0d.pcw", tag, i), pc_wen, v.pcw);
      chk($sformatf("%s.c%0d.halted", tag, i), halted, v.hltd);
      chk($sformatf("%s.c%0d.err", tag, i), err, v.er);
      chk($sformatf("%s.c%0d.cyc", tag, i), cycle_cnt, v.cyc);
      chk($sformatf("%s.c%0d.ret", tag, i), instret_cnt, v.ret);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-to-back minimum-latency instructions.
    start_run("min");
    for (int i = 0; i < 3; i++) add_inst(0, 32'h0000_0013 + i, 32'h8000_0000 + 4 * i, 0, 1'b1, 1'b0);
    run_q("min");

    start_run("ackdly");
    add_inst(3, 32'h0010_0093, 32'h8000_0100, 0, 1'b1, 1'b0);
    run_q("ackdly");

    start_run("donedly");
    add_inst(0, 32'h1234_5678, 32'h8000_0200, 5, 1'b0, 1'b0);
    add_inst(0, 32'h0000_0073, 32'h8000_0204, 0, 1'b0, 1'b0);
    run_q("donedly");

    start_run("halt");
    add_inst(0, 32'h0010_0073, 32'h8000_0300, 0, 1'b1, 1'b1);
    run_q("halt");

    start_run("tmo");
    add_inst(TMO + 1, 32'hdead_beef, 32'h8000_0400, 0, 1'b1, 1'b0);
    run_q("tmo");

    start_run("tmoack");
    add_inst(TMO, 32'hcafe_f00d, 32'h8000_0500, 0, 1'b1, 1'b0);
    add_inst(0, 32'h0000_0013, 32'h8000_0504, 0, 1'b1, 1'b0);
    run_q("tmoack");

    // Async reset in the middle of EXEC with ex_done pending.
    start_run("abort");
    push(K_FETCH, 1'b1, 32'h0aaa_0aaa, 1'b1, 1'b1, 1'b0, 32'h8000_0600);
    m_inst = 32'h0aaa_0aaa;
    push(K_DEC, 1'b0, $urandom, 1'b1, 1'b1, 1'b0, 32'h8000_0600);
    push(K_EXEC, 1'b0, $urandom, 1'b0, 1'b1, 1'b0, 32'h8000_0600);
    push(K_EXEC, 1'b0, $urandom, 1'b0, 1'b1, 1'b0, 32'h8000_0600);
    run_q("abort.pre");
    ex_done = 1'b1; ex_rf_wen = 1'b1; imem_ack = 1'b1;
    #2 rst = 1'b1;
    #1 check_zero("abort.async");
    @(posedge clk); #1;
    check_zero("abort.held");
    release_and_init();
    for (int i = 0; i < 3; i++) add_inst(0, 32'h0000_0113 + i, 32'h8000_0700 + 4 * i, 0, 1'b1, 1'b0);
    push(K_FETCH, 1'b0, $urandom, 1'b0, 1'b0, 1'b0, 32'h8000_070c);
    run_q("abort.post");

    for (int r = 0; r < 20; r++) begin
      int n;
      logic [31:0] p;
      start_run($sformatf("rnd%0d", r));
      n = $urandom_range(1, 6);
      p = $urandom & 32'hffff_fffc;
      for (int i = 0; i < n; i++) begin
        int rr, da;
        rr = $urandom_range(0, 9);
        da = (rr < 8) ? (rr % 4) : TMO + 1;
        add_inst(da, $urandom, p, $urandom_range(0, 6), rb(), ($urandom_range(0, 7) == 0));
        p = p + 32'd4;
      end
      run_q($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
